mux64x1_reg: RTL and testbench

- 64-to-1 single-bit multiplexer with a registered output.
- Built as a two-level tree of 8:1 muxes: eight leaf 8:1 muxes select on sel[2:0], and one root 8:1 mux selects on sel[5:3].
- Optional pipeline register between the tree levels.
- A valid bit travels alongside the data so downstream logic knows when out reflects a sampled in/sel pair.
- Used as a generic bit-select stage in datapaths.

---
 rtl/mux64x1_reg_if.sv | 12 +
 rtl/mux64x1_reg.sv | 71 +++++++
 tb/tb_mux64x1_reg.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mux64x1_reg_if.sv
// mux64x1_reg_if: sample/result bundle for the registered 64:1 bit-select.
// The master drives in/sel/in_valid; the slave returns out/out_valid.
interface mux64x1_reg_if;
    logic [63:0] in;
    logic [5:0]  sel;
    logic        in_valid;
    logic        out;
    logic        out_valid;

    modport master (output in, sel, in_valid, input out, out_valid);
    modport slave  (input in, sel, in_valid, output out, out_valid);
endinterface

// File: rtl/mux64x1_reg.sv
// mux64x1_reg: 64:1 single-bit mux built as eight 8:1 leaves plus an 8:1 root,
// with a registered output and an optional register between the two levels.
module mux64x1_reg #(
    parameter int LATENCY = 1
) (
    input logic          clk,
    input logic          rst,
    mux64x1_reg_if.slave bus
);
    logic [7:0] leaf_d;
    logic [2:0] hi_d;
    logic       vld_d;
    logic       out_d;
    logic       out_valid_d;
    logic       out_q;
    logic       out_valid_q;

    always_comb begin
        leaf_d = '0;
        for (int j = 0; j < 8; j++)
            leaf_d[j] = bus.in[{j[2:0], bus.sel[2:0]}];
        hi_d  = bus.sel[5:3];
        vld_d = bus.in_valid;
    end

    if (LATENCY == 2) begin : g_pipe
        logic [7:0] leaf_q;
        logic [2:0] hi_q;
        logic       vld_q;

        // sel[5:3] travels with the leaf data so the root never sees a skewed index
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                leaf_q <= '0;
                hi_q   <= '0;
                vld_q  <= 1'b0;
            end else begin
                leaf_q <= leaf_d;
                hi_q   <= hi_d;
                vld_q  <= vld_d;
            end
        end

        always_comb begin
            out_d       = leaf_q[hi_q];
            out_valid_d = vld_q;
        end
    end else begin : g_direct
        if (LATENCY != 1) begin : g_bad
            $error("mux64x1_reg: LATENCY must be 1 or 2");
        end

        always_comb begin
            out_d       = leaf_d[hi_d];
            out_valid_d = vld_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux64x1_reg.sv
// tb_mux64x1_reg: drives LATENCY=1 and LATENCY=2 instances with identical stimulus
// and compares both against a history of in[sel] / in_valid samples.
module tb_mux64x1_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   hist_bit[$];
    bit   hist_vld[$];
    bit   sweep_obs[64];
    int   ones;

    localparam logic [63:0] PAT = 64'h0123_4567_89ab_cdef;
    int pts[8] = '{0, 4, 8, 9, 32, 35, 56, 63};
    bit pvals[8] = '{1, 0, 1, 0, 1, 0, 1, 0};

    mux64x1_reg_if b1 ();
    mux64x1_reg_if b2 ();

    mux64x1_reg #(.LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(b1));
    mux64x1_reg #(.LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(b2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // value sampled l edges ago since the last reset, 0 if not that many yet
    function automatic bit past_bit(int l);
        return hist_bit.size() >= l ? hist_bit[hist_bit.size() - l] : 1'b0;
    endfunction

    function automatic bit past_vld(int l);
        return hist_vld.size() >= l ? hist_vld[hist_vld.size() - l] : 1'b0;
    endfunction

    task automatic step(input string tag, input logic [63:0] d, input logic [5:0] s, input logic v);
        logic [63:0] sh;
        @(negedge clk);
        b1.in = d; b1.sel = s; b1.in_valid = v;
        b2.in = d; b2.sel = s; b2.in_valid = v;
        @(posedge clk);
        if (!rst) begin
            sh = d >> s;
            hist_bit.push_back(sh[0]);
            hist_vld.push_back(v);
        end
        #1;
        check({tag, "_l1_out"}, b1.out, past_bit(1));
        check({tag, "_l1_vld"}, b1.out_valid, past_vld(1));
        check({tag, "_l2_out"}, b2.out, past_bit(2));
        check({tag, "_l2_vld"}, b2.out_valid, past_vld(2));
    endtask

    initial begin
        logic [63:0] d;
        b1.in = '0; b1.sel = '0; b1.in_valid = 1'b0;
        b2.in = '0; b2.sel = '0; b2.in_valid = 1'b0;
        #1;
        check("rst_l1_out", b1.out, 1'b0);
        check("rst_l2_vld", b2.out_valid, 1'b0);
        step("rst_hold", '1, 6'd0, 1'b1);
        #2 rst = 1'b0;

        ones = 0;
        for (int s = 0; s < 64; s++) begin
            step("sweep", PAT, 6'(s), 1'b1);
            sweep_obs[s] = b1.out;
            ones += int'(b1.out);
        end
        for (int i = 0; i < 8; i++)
            check($sformatf("sweep_pt%0d", pts[i]), sweep_obs[pts[i]], pvals[i]);
        checks++;
        assert (ones == 32) else begin
            failures++;
            $error("FAIL sweep_ones observed=%0d expected=32", ones);
        end

        for (int k = 0; k < 64; k++) step("walk_hit", 64'd1 << k, 6'(k), 1'b1);
        for (int k = 0; k < 64; k++) step("walk_miss", 64'd1 << k, 6'((k + 1) % 64), 1'b1);

        for (int i = 0; i < 16; i++)
            step("b2b", i % 2 == 0 ? '1 : 64'd0, i % 2 == 0 ? 6'd5 : 6'd60, 1'b1);

        for (int i = 0; i < 200; i++)
            step("rand", {$urandom, $urandom}, 6'($urandom_range(63)), 1'($urandom_range(1)));

        for (int i = 0; i < 3; i++) step("gate_off", '1, 6'($urandom_range(63)), 1'b0);
        for (int i = 0; i < 3; i++) step("gate_on", '1, 6'($urandom_range(63)), 1'b1);

        // reset lands between edges while both outputs are high
        #2 rst = 1'b1;
        #1;
        check("arst_l1_out", b1.out, 1'b0);
        check("arst_l1_vld", b1.out_valid, 1'b0);
        check("arst_l2_out", b2.out, 1'b0);
        check("arst_l2_vld", b2.out_valid, 1'b0);
        hist_bit.delete();
        hist_vld.delete();
        step("arst_hold", '1, 6'd7, 1'b1);
        step("arst_hold", '1, 6'd7, 1'b1);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) step("arst_rel", PAT, 6'd0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            int s = $urandom_range(63);
            d = {$urandom, $urandom};
            d[s] = 1'b1;
            step("unsel_noise", d, 6'(s), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
